iso_pwr_seq: RTL and testbench
==============================

Name: iso_pwr_seq

Overview:
- Parametrised per-domain isolation and power sequencer for switchable blocks (BLKB/BLKC-class domains) feeding always-on logic.
- Generalises fixed ISOB/ISOC-driven isolation to NDOM independent channels.
- Each channel has a registered FSM that orders isolate -> power-down -> power-up -> release, waits for power-switch acknowledge with timeout, and applies the clamp on the domain's output bus.

Parameters:
NDOM, 2, number of independent power domains
WIDTH, 8, output bits per domain crossing into always-on logic
ISO_DLY, 4, cycles between an isolation edge and the adjacent power edge (>=1)
TMO, 16, max cycles to wait for PWR_ACK before flagging error (>=2)

Ports:
CLK  input  1  system clock, always-on
RSTN  input  1  asynchronous active-low reset
REQ_OFF  input  NDOM  per-domain power-off request, level, sampled only in ON
REQ_ON  input  NDOM  per-domain power-on request, level, sampled only in OFF
PWR_ACK  input  NDOM  power-switch status, 1 = rail good; treated as synchronous
CLAMP_VAL  input  NDOM  clamp level for domain k outputs while isolated
D_IN  input  NDOM*WIDTH  raw outputs of switchable domains; slice k = [k*WIDTH +: WIDTH]
Y_OUT  output  NDOM*WIDTH  isolated outputs to always-on logic
ISO  output  NDOM  isolation enable per domain, 1 = clamped
PWR_EN  output  NDOM  power-switch enable per domain
DONE  output  NDOM  one-cycle pulse on entry to ON or OFF
ERR  output  NDOM  sticky acknowledge-timeout flag

Behaviour:
- Clock and reset: one clock, CLK. RSTN is asynchronous and active-low.
- Channels are fully independent. Each has a state register, a counter of width clog2(max(ISO_DLY,TMO))+1, and registered ISO, PWR_EN, DONE and ERR.
- Reset values: state = PWR_UP, ISO = all 1, PWR_EN = all 1, DONE = 0, ERR = 0, counter = 0.
- Y_OUT slice k is combinational: {WIDTH{CLAMP_VAL[k]}} when ISO[k] = 1, otherwise D_IN slice k. Y_OUT is therefore clamped throughout reset.
- ON: ISO = 0, PWR_EN = 1.
  - When REQ_OFF[k] = 1, go to ISO_SET, clear the counter, and set ERR = 0. ISO rises the next cycle.
  - REQ_ON is ignored in this state.
- ISO_SET: ISO = 1, PWR_EN = 1.
  - Counter increments each cycle. When counter = ISO_DLY-1, go to PWR_DN and clear the counter.
  - PWR_EN falls exactly ISO_DLY cycles after ISO rises.
- PWR_DN: ISO = 1, PWR_EN = 0.
  - If PWR_ACK = 0, go to OFF.
  - Otherwise, when counter = TMO-1, set ERR = 1 and go to OFF.
- OFF: ISO = 1, PWR_EN = 0.
  - When REQ_ON[k] = 1, go to PWR_UP, clear the counter, and set ERR = 0.
  - REQ_OFF is ignored in this state.
- PWR_UP: ISO = 1, PWR_EN = 1.
  - If PWR_ACK = 1, go to ISO_REL and clear the counter.
  - Otherwise, when counter = TMO-1, set ERR = 1, drive PWR_EN = 0 and go to OFF. ISO is never released on a failed power-up.
- ISO_REL: ISO = 1, PWR_EN = 1.
  - When counter = ISO_DLY-1, go to ON; ISO falls on entry to ON.
  - If PWR_ACK drops while in ISO_REL, go to OFF with PWR_EN = 0 and ERR = 1.
- DONE[k] is high for exactly the first cycle after entering ON or OFF, including the first ON after reset and the timeout entries into OFF.
- Ordering invariant, checkable by assertion: for each k, PWR_EN never changes in the same cycle as ISO, and ISO = 0 implies PWR_EN = 1 and state = ON.
- REQ held high: one transition sequence per entry into ON or OFF. If REQ_OFF is still high on return to ON, a new power-down starts the next cycle.
- RSTN asserted mid-sequence: all channels immediately reload reset values (PWR_EN = 1, ISO = 1), then re-run PWR_UP -> ISO_REL -> ON.

Test Plan:
- Reset release: NDOM=2, WIDTH=8, ISO_DLY=4, TMO=16, PWR_ACK=2'b11, CLAMP_VAL=2'b10, D_IN=16'hA55A. Required: Y_OUT=16'hFF00 during reset; PWR_UP -> ISO_REL; ISO falls 5 cycles after RSTN high; DONE pulses; Y_OUT=16'hA55A.
- Power-off, domain 0: REQ_OFF=2'b01, PWR_ACK[0] falls 3 cycles after PWR_EN[0]. Required: ISO[0] rises 1 cycle after REQ_OFF, PWR_EN[0] falls 4 cycles later, DONE[0] pulses on OFF entry; domain 1 undisturbed; Y_OUT[7:0]=8'h00.
- Power-down timeout: PWR_ACK[1] stuck at 1 after REQ_OFF[1]. Required: 16 cycles in PWR_DN, ERR[1]=1, OFF, DONE[1] pulse.
- Power-up timeout: from OFF, REQ_ON[0] with PWR_ACK[0] stuck at 0. Required: PWR_EN[0]=1 for 16 cycles, then 0; ERR[0]=1; ISO[0] stays 1.
- Simultaneous and held requests: REQ_ON and REQ_OFF both high on both channels. Required: continuous ON/OFF cycling; ordering invariant holds every cycle; RSTN pulsed mid ISO_SET forces ISO=1 and PWR_EN=1 asynchronously.

Source files
------------

// File: rtl/iso_pwr_seq.sv
// rtl/iso_pwr_seq.sv - per-domain isolation and power sequencer with clamped outputs
// Each channel orders isolate -> power-down -> power-up -> release and times out on a missing switch ack.
module iso_pwr_seq #(
  parameter int NDOM    = 2,
  parameter int WIDTH   = 8,
  parameter int ISO_DLY = 4,
  parameter int TMO     = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NDOM-1:0]       req_off,
  input  logic [NDOM-1:0]       req_on,
  input  logic [NDOM-1:0]       pwr_ack,
  input  logic [NDOM-1:0]       clamp_val,
  input  logic [NDOM*WIDTH-1:0] d_in,
  output logic [NDOM*WIDTH-1:0] y_out,
  output logic [NDOM-1:0]       iso,
  output logic [NDOM-1:0]       pwr_en,
  output logic [NDOM-1:0]       done,
  output logic [NDOM-1:0]       err
);

  localparam int MAXC = (ISO_DLY > TMO) ? ISO_DLY : TMO;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO_SET = 3'd1,
    ST_PWR_DN  = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWR_UP  = 3'd4,
    ST_ISO_REL = 3'd5
  } state_t;

  for (genvar k = 0; k < NDOM; k++) begin : g_dom
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iso_q, iso_d;
    logic          pen_q, pen_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= ST_PWR_UP;
        cnt_q   <= '0;
        iso_q   <= 1'b1;
        pen_q   <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        iso_q   <= iso_d;
        pen_q   <= pen_d;
        done_q  <= done_d;
        err_q   <= err_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      err_d   = err_q;
      case (state_q)
        ST_ON: begin
          cnt_d = '0;
          if (req_off[k]) begin
            state_d = ST_ISO_SET;
            err_d   = 1'b0;
          end
        end
        ST_ISO_SET: begin
          if (cnt_q == ISO_LAST) begin
            state_d = ST_PWR_DN;
            cnt_d   = '0;
          end
        end
        ST_PWR_DN: begin
          if (!pwr_ack[k]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
        ST_OFF: begin
          cnt_d = '0;
          if (req_on[k]) begin
            state_d = ST_PWR_UP;
            err_d   = 1'b0;
          end
        end
        ST_PWR_UP: begin
          if (pwr_ack[k]) begin
            state_d = ST_ISO_REL;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
        ST_ISO_REL: begin
          // A rail that collapses during release must never see isolation drop.
          if (!pwr_ack[k]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else if (cnt_q == ISO_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_PWR_UP;
          cnt_d   = '0;
        end
      endcase

      // Outputs are registered from the next state so they change on the state edge.
      iso_d  = (state_d != ST_ON);
      pen_d  = !((state_d == ST_PWR_DN) || (state_d == ST_OFF));
      done_d = (state_d != state_q) && ((state_d == ST_ON) || (state_d == ST_OFF));
    end

    assign iso[k]    = iso_q;
    assign pwr_en[k] = pen_q;
    assign done[k]   = done_q;
    assign err[k]    = err_q;
    assign y_out[k*WIDTH +: WIDTH] = iso_q ? {WIDTH{clamp_val[k]}} : d_in[k*WIDTH +: WIDTH];
  end

endmodule

// File: tb/tb_iso_pwr_seq.sv
// tb/tb_iso_pwr_seq.sv - scoreboard bench for iso_pwr_seq
// Expected channel state at each DONE pulse is queued by stimulus and popped by the monitor.
module tb_iso_pwr_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_off = '0;
  logic [1:0]  req_on = '0;
  logic [1:0]  ack_drv = 2'b11;
  logic        follow = 1'b0;
  logic [1:0]  pwr_ack;
  logic [1:0]  clamp_val = 2'b10;
  logic [15:0] d_in = 16'hA55A;
  logic [15:0] y_out;
  logic [1:0]  iso, pwr_en, done, err;

  int nchk = 0;
  int npass = 0;
  logic freerun = 1'b0;

  typedef struct packed {
    logic       err;
    logic       iso;
    logic       pen;
    logic [7:0] y;
  } exp_t;

  exp_t sb [2][$];

  assign pwr_ack = follow ? pwr_en : ack_drv;

  always #5 clk = ~clk;

  iso_pwr_seq #(.NDOM(2), .WIDTH(8), .ISO_DLY(4), .TMO(16)) dut (
    .clk(clk), .rstn(rstn), .req_off(req_off), .req_on(req_on), .pwr_ack(pwr_ack),
    .clamp_val(clamp_val), .d_in(d_in), .y_out(y_out), .iso(iso), .pwr_en(pwr_en),
    .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic exp_t mk_on(input int k);
    exp_t e;
    e.err = 1'b0; e.iso = 1'b0; e.pen = 1'b1; e.y = d_in[k*8 +: 8];
    return e;
  endfunction

  function automatic exp_t mk_off(input int k, input logic e_err);
    exp_t e;
    e.err = e_err; e.iso = 1'b1; e.pen = 1'b0; e.y = {8{clamp_val[k]}};
    return e;
  endfunction

  task automatic wait_empty(input string name, input int maxc);
    int n = 0;
    while ((sb[0].size() + sb[1].size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, sb[0].size() + sb[1].size(), 0);
  endtask

  logic [1:0] prev_iso, prev_pen;
  logic       prev_run = 1'b0;
  exp_t       got_e, want_e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rstn && done[k]) begin
        got_e = {err[k], iso[k], pwr_en[k], y_out[k*8 +: 8]};
        if (sb[k].size() > 0) begin
          want_e = sb[k].pop_front();
          check($sformatf("done%0d_state", k), 32'(got_e), 32'(want_e));
        end else if (!freerun) begin
          nchk++;
          $display("FAIL done%0d_unexpected: got pulse with state %h want no pulse", k, got_e);
        end
      end
      if (rstn && prev_run) begin
        check($sformatf("order%0d", k),
              32'((iso[k] || pwr_en[k]) && !((iso[k] != prev_iso[k]) && (pwr_en[k] != prev_pen[k]))),
              32'd1);
      end
    end
    prev_iso = iso;
    prev_pen = pwr_en;
    prev_run = rstn;
  end

  initial begin
    int c;
    logic iso_held;

    // Reset: outputs clamped, both channels come up through ISO_REL.
    repeat (2) @(negedge clk);
    check("rst_y", y_out, 16'hFF00);
    check("rst_iso_pen", {iso, pwr_en}, 4'b1111);
    check("rst_done_err", {done, err}, 4'b0000);
    sb[0].push_back(mk_on(0));
    sb[1].push_back(mk_on(1));
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("iso_before_5", iso, 2'b11);
    @(negedge clk);
    check("iso_fall_5", iso, 2'b00);
    check("y_on", y_out, 16'hA55A);
    wait_empty("reset_done", 5);

    // Power-off domain 0 with ack falling 3 cycles after PWR_EN.
    sb[0].push_back(mk_off(0, 1'b0));
    req_off = 2'b01;
    @(negedge clk);
    req_off = 2'b00;
    check("iso0_rise", {iso[0], pwr_en[0]}, 2'b11);
    repeat (3) @(negedge clk);
    check("pen0_hold", pwr_en[0], 1'b1);
    @(negedge clk);
    check("pen0_fall", pwr_en[0], 1'b0);
    repeat (3) @(negedge clk);
    ack_drv[0] = 1'b0;
    wait_empty("off0_done", 10);
    check("off0_y", y_out, 16'hA500);
    check("dom1_undisturbed", {iso[1], pwr_en[1], err[1]}, 3'b010);

    // Power-down timeout on domain 1: ack stuck high.
    sb[1].push_back(mk_off(1, 1'b1));
    req_off = 2'b10;
    @(negedge clk);
    req_off = 2'b00;
    c = 0;
    while (pwr_en[1] && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("pen1_fell", pwr_en[1], 1'b0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done[1] && c < 40);
    check("pwr_dn_cycles", c, 16);
    wait_empty("off1_done", 5);

    // Power-up timeout on domain 0: ack stuck low.
    sb[0].push_back(mk_off(0, 1'b1));
    req_on = 2'b01;
    @(negedge clk);
    req_on = 2'b00;
    c = 0;
    iso_held = 1'b1;
    while (pwr_en[0] && c < 40) begin
      c++;
      iso_held = iso_held & iso[0];
      @(negedge clk);
    end
    check("pwr_up_cycles", c, 16);
    check("pwr_up_iso_held", {iso_held, iso[0]}, 2'b11);
    wait_empty("up0_tmo_done", 5);

    // Held requests with ack following the switch: continuous cycling.
    follow = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb[k].push_back(mk_on(k));
      sb[k].push_back(mk_off(k, 1'b0));
      sb[k].push_back(mk_on(k));
      sb[k].push_back(mk_off(k, 1'b0));
    end
    req_on = 2'b11;
    req_off = 2'b11;
    wait_empty("cycling", 200);
    freerun = 1'b1;
    c = 0;
    while (iso[0] && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("cyc_reach_on", iso[0], 1'b0);
    @(negedge clk);
    check("cyc_iso_set", {iso[0], pwr_en[0]}, 2'b11);

    // Asynchronous reset in the middle of ISO_SET.
    #3;
    rstn = 1'b0;
    req_on = 2'b00;
    req_off = 2'b00;
    #1;
    check("async_rst_iso_pen", {iso, pwr_en}, 4'b1111);
    check("async_rst_done_err", {done, err}, 4'b0000);
    check("async_rst_y", y_out, 16'hFF00);
    freerun = 1'b0;
    sb[0].push_back(mk_on(0));
    sb[1].push_back(mk_on(1));
    @(negedge clk);
    rstn = 1'b1;
    wait_empty("rerun_on", 20);
    repeat (5) @(negedge clk);
    check("final_on", {iso, pwr_en, err}, 6'b001100);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
